mul_div_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit for the EXE stage of the LoongArch pipeline. It is the successor to the single-cycle ALU multiply path.
- Handles mul.w, mulh.w, mulh.wu, div.w, mod.w, div.wu and mod.wu behind valid/ready handshakes.
- Multiply completes in one registered cycle. Divide uses an iterative radix-2 restoring divider.
- The pipeline holds EXE while the unit is busy, and uses cancel to kill in-flight work on exception or ertn flush.

---
 rtl/mul_div_unit.sv | 168 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit -- multi-cycle multiply / radix-2 restoring divide for the EXE stage
// Revision: 1.0
`default_nettype none

module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cancel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       mdu_op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [6:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vld_q, vld_d;

  // Malformed opcodes (none or several bits set) fall back to mul.
  logic             op_onehot;
  logic [6:0]       op_in;
  logic             in_is_div, in_signed;
  logic [WIDTH-1:0] mag1, mag2, dz_res;

  assign op_onehot = (mdu_op != 7'd0) && ((mdu_op & (mdu_op - 7'd1)) == 7'd0);
  assign op_in     = op_onehot ? mdu_op : 7'b0000001;
  assign in_is_div = |op_in[6:3];
  assign in_signed = op_in[3] | op_in[4];
  assign mag1      = (in_signed && src1[WIDTH-1]) ? -src1 : src1;
  assign mag2      = (in_signed && src2[WIDTH-1]) ? -src2 : src2;
  assign dz_res    = (op_in[3] | op_in[5]) ? {WIDTH{1'b1}} : src1;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]   mul_res;

  assign prod_s  = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign prod_u  = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
  assign mul_res = op_q[0] ? prod_s[WIDTH-1:0] :
                   op_q[1] ? prod_s[2*WIDTH-1:WIDTH] : prod_u[2*WIDTH-1:WIDTH];

  // Trial subtract is one bit wider; its MSB is the borrow (remainder < divisor always holds).
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] step_quo, step_rem, fix_quo, fix_rem, div_res;
  logic             div_signed;

  assign trial      = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
  assign step_quo   = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  assign step_rem   = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
  assign div_signed = op_q[3] | op_q[4];
  assign fix_quo    = (div_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -step_quo : step_quo;
  assign fix_rem    = (div_signed && a_q[WIDTH-1]) ? -step_rem : step_rem;
  assign div_res    = (op_q[3] | op_q[5]) ? fix_quo : fix_rem;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    if (cancel) begin
      state_d = IDLE;
      vld_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_d  = op_in;
            a_d   = src1;
            b_d   = src2;
            quo_d = mag1;
            dvs_d = mag2;
            rem_d = '0;
            if (!in_is_div) begin
              state_d = MUL;
            end else if (src2 == '0) begin
              state_d = DONE;
              res_d   = dz_res;
              vld_d   = 1'b1;
            end else begin
              state_d = DIV;
              cnt_d   = CNT_W'(WIDTH);
            end
          end
        end
        MUL: begin
          state_d = DONE;
          res_d   = mul_res;
          vld_d   = 1'b1;
        end
        DIV: begin
          quo_d = step_quo;
          rem_d = step_rem;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
            res_d   = div_res;
            vld_d   = 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
            vld_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
    end
  end

  assign in_ready   = (state_q == IDLE) & ~cancel;
  assign out_valid  = vld_q;
  assign out_result = res_q;
  assign busy       = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit -- directed vector table plus handshake / cancel / reset sequences
// Revision: 1.0
`default_nettype none

module tb_mul_div_unit;

  localparam logic [6:0] OP_MUL   = 7'b0000001;
  localparam logic [6:0] OP_MULH  = 7'b0000010;
  localparam logic [6:0] OP_MULHU = 7'b0000100;
  localparam logic [6:0] OP_DIV   = 7'b0001000;
  localparam logic [6:0] OP_MOD   = 7'b0010000;
  localparam logic [6:0] OP_DIVU  = 7'b0100000;
  localparam logic [6:0] OP_MODU  = 7'b1000000;
  localparam int         NVEC     = 24;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cancel = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  mdu_op = 7'd0;
  logic [31:0] src1 = 32'd0;
  logic [31:0] src2 = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        busy;

  int n_pass = 0;
  int n_total = 0;

  mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .cancel    (cancel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mdu_op    (mdu_op),
    .src1      (src1),
    .src2      (src2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Issue one request from IDLE, measure edges to out_valid (accept edge = 1), then consume it.
  task automatic run_op(input string name, input logic [6:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n;
    @(negedge clk);
    check({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; mdu_op = op; src1 = a; src2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " latency"}, n, lat);
    check({name, " result"}, out_result, exp);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, " consumed"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " wait out_valid"}, {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    int seen;
    vecs[0]  = '{OP_MUL,   32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 2};
    vecs[1]  = '{OP_MULH,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 2};
    vecs[2]  = '{OP_MULHU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 2};
    vecs[3]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33};
    vecs[4]  = '{OP_MOD,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33};
    vecs[5]  = '{OP_DIVU,  32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 33};
    vecs[6]  = '{OP_MODU,  32'hFFFFFFF9, 32'h00000002, 32'h00000001, 33};
    vecs[7]  = '{OP_DIV,   32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1};
    vecs[8]  = '{OP_MOD,   32'h12345678, 32'h00000000, 32'h12345678, 1};
    vecs[9]  = '{OP_DIVU,  32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1};
    vecs[10] = '{OP_MODU,  32'h12345678, 32'h00000000, 32'h12345678, 1};
    vecs[11] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33};
    vecs[12] = '{OP_MOD,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33};
    vecs[13] = '{OP_DIVU,  32'd100,      32'd7,        32'd14,       33};
    vecs[14] = '{OP_MODU,  32'd100,      32'd7,        32'd2,        33};
    vecs[15] = '{OP_MUL,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 2};
    vecs[16] = '{OP_MULH,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 2};
    vecs[17] = '{OP_DIV,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFFE, 33};
    vecs[18] = '{OP_MOD,   32'd7,        32'hFFFFFFFD, 32'h00000001, 33};
    vecs[19] = '{OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2};
    vecs[20] = '{OP_MULH,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 2};
    vecs[21] = '{7'b0000000, 32'd3,      32'd5,        32'd15,       2};
    vecs[22] = '{7'b0011000, 32'd3,      32'd5,        32'd15,       2};
    vecs[23] = '{OP_MOD,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 33};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset out_result", out_result, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < NVEC; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Backpressure: result and in_ready frozen while out_ready is low.
    @(negedge clk);
    in_valid = 1'b1; mdu_op = OP_MUL; src1 = 32'd6; src2 = 32'd9;
    @(posedge clk); #1;
    mdu_op = OP_DIVU; src1 = 32'd1; src2 = 32'd1;
    wait_valid("bp");
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp out_valid c%0d", c), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp result c%0d", c), out_result, 32'd54);
      check($sformatf("bp in_ready c%0d", c), {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp consumed", {31'd0, out_valid}, 32'd0);
    check("bp in_ready back", {31'd0, in_ready}, 32'd1);

    // Cancel at divide iteration 10 with a competing request.
    @(negedge clk);
    in_valid = 1'b1; mdu_op = OP_DIVU; src1 = 32'd1000; src2 = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    cancel = 1'b1; in_valid = 1'b1; mdu_op = OP_MUL; src1 = 32'd2; src2 = 32'd2;
    #1 check("cancel in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    cancel = 1'b0; in_valid = 1'b0;
    check("cancel busy", {31'd0, busy}, 32'd0);
    check("cancel out_valid", {31'd0, out_valid}, 32'd0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen++;
    end
    check("cancel no pulse", seen, 0);
    run_op("post-cancel divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);

    // Cancel in DONE while out_ready is high discards the result but keeps out_result.
    @(negedge clk);
    in_valid = 1'b1; mdu_op = OP_MUL; src1 = 32'd3; src2 = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid("done-cancel");
    @(negedge clk);
    cancel = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0; out_ready = 1'b0;
    check("done-cancel out_valid", {31'd0, out_valid}, 32'd0);
    check("done-cancel out_result held", out_result, 32'd15);
    check("done-cancel busy", {31'd0, busy}, 32'd0);

    // Reset in the MUL state.
    @(negedge clk);
    in_valid = 1'b1; mdu_op = OP_MUL; src1 = 32'd4; src2 = 32'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rst-mul busy before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst-mul out_valid", {31'd0, out_valid}, 32'd0);
    check("rst-mul out_result", out_result, 32'd0);
    check("rst-mul busy", {31'd0, busy}, 32'd0);
    run_op("post-reset mul", OP_MUL, 32'd12, 32'd11, 32'd132, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
